// File: rtl/stage3_issue_latch_if.sv
// Stage-2 to stage-3 pipeline latch bus: stage-2 payload and hazard controls in,
// latched stage-3 state, flags and hazard request out.
interface stage3_issue_latch_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] ir_in;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] r1_in;
  logic [DATA_W-1:0] r2_in;
  logic              valid_in;
  logic              stall;
  logic              flush;
  logic              alu_n;
  logic              alu_z;
  logic              flag_write;
  logic [3:0]        instr_op;
  logic [DATA_W-1:0] ir_out;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] r1_out;
  logic [DATA_W-1:0] r2_out;
  logic              valid_out;
  logic              NwireOut;
  logic              ZwireOut;
  logic              hazard_stall;
  logic              halted;

  modport master (
    output ir_in, pc_in, r1_in, r2_in, valid_in, stall, flush, alu_n, alu_z, flag_write,
    input  instr_op, ir_out, pc_out, r1_out, r2_out, valid_out, NwireOut, ZwireOut,
           hazard_stall, halted
  );

  modport slave (
    input  ir_in, pc_in, r1_in, r2_in, valid_in, stall, flush, alu_n, alu_z, flag_write,
    output instr_op, ir_out, pc_out, r1_out, r2_out, valid_out, NwireOut, ZwireOut,
           hazard_stall, halted
  );
endinterface

// File: rtl/stage3_issue_latch.sv
// Register-read to execute pipeline latch with bubble insertion on flush / load-use,
// the N/Z flag register and the sticky STOP halt.
module stage3_issue_latch #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] NOP_IR  = 8'h0A,
  parameter logic [1:0]        ORI_SRC = 2'b01
) (
  input logic                 clock,
  input logic                 reset,
  stage3_issue_latch_if.slave bus
);

  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] r1_reg;
  logic [DATA_W-1:0] r2_reg;
  logic              valid_reg;
  logic              n_reg;
  logic              z_reg;
  logic              halted_reg;

  logic [3:0] in_op;
  logic [1:0] in_rs;
  logic [1:0] in_rt;
  logic       is_ori;
  logic       is_shift;
  logic       is_two_src;
  logic       is_load_in;
  logic [3:0] src_hit;
  logic       hazard;

  assign in_op      = bus.ir_in[3:0];
  assign in_rs      = bus.ir_in[7:6];
  assign in_rt      = bus.ir_in[5:4];
  // ORI and shift are 3-bit opcodes; test them before the full-nibble classes.
  assign is_ori     = (in_op[2:0] == 3'b111);
  assign is_shift   = (in_op[2:0] == 3'b011);
  assign is_two_src = (in_op == 4'b0100) || (in_op == 4'b0110) ||
                      (in_op == 4'b1000) || (in_op == 4'b0010);
  assign is_load_in = (in_op == 4'b0000);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
      localparam logic [1:0] REG_IDX = 2'(gi);
      assign src_hit[gi] = is_ori     ? (ORI_SRC == REG_IDX) :
                           is_shift   ? (in_rs == REG_IDX) :
                           is_two_src ? ((in_rs == REG_IDX) || (in_rt == REG_IDX)) :
                           is_load_in ? (in_rt == REG_IDX) :
                                        1'b0;
    end
  endgenerate

  assign hazard = valid_reg && bus.valid_in && !halted_reg && !bus.flush &&
                  (ir_reg[3:0] == 4'b0000) && src_hit[ir_reg[7:6]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_reg     <= NOP_IR;
      pc_reg     <= '0;
      r1_reg     <= '0;
      r2_reg     <= '0;
      valid_reg  <= 1'b0;
      n_reg      <= 1'b0;
      z_reg      <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      // Flags belong to the instruction already in stage 3, so a flush does not cancel them.
      if (valid_reg && bus.flag_write && !bus.stall) begin
        n_reg <= bus.alu_n;
        z_reg <= bus.alu_z;
      end
      if (valid_reg && (ir_reg[3:0] == 4'b0001) && !bus.stall)
        halted_reg <= 1'b1;

      if (bus.flush || halted_reg || (!bus.stall && hazard)) begin
        ir_reg    <= NOP_IR;
        pc_reg    <= '0;
        r1_reg    <= '0;
        r2_reg    <= '0;
        valid_reg <= 1'b0;
      end else if (!bus.stall) begin
        ir_reg    <= bus.valid_in ? bus.ir_in : NOP_IR;
        pc_reg    <= bus.pc_in;
        r1_reg    <= bus.r1_in;
        r2_reg    <= bus.r2_in;
        valid_reg <= bus.valid_in;
      end
    end
  end

  assign bus.instr_op     = ir_reg[3:0];
  assign bus.ir_out       = ir_reg;
  assign bus.pc_out       = pc_reg;
  assign bus.r1_out       = r1_reg;
  assign bus.r2_out       = r2_reg;
  assign bus.valid_out    = valid_reg;
  assign bus.NwireOut     = n_reg;
  assign bus.ZwireOut     = z_reg;
  assign bus.hazard_stall = hazard;
  assign bus.halted       = halted_reg;

endmodule

// File: tb/tb_stage3_issue_latch.sv
// Self-checking bench for stage3_issue_latch: directed scenarios then randomized
// traffic compared against a behavioural model of the pipeline slot.
module tb_stage3_issue_latch;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  stage3_issue_latch_if bus ();

  stage3_issue_latch dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Model of the stage-3 slot.
  logic [7:0] m_ir, m_pc, m_r1, m_r2;
  logic       m_valid, m_n, m_z, m_halted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Does the instruction read register r as a source?
  function automatic bit reads(input logic [7:0] ir, input logic [1:0] r);
    logic [3:0] op;
    op = ir[3:0];
    if (op[2:0] == 3'b111) return r == 2'd1;                       // ORI reads k1
    if (op[2:0] == 3'b011) return r == ir[7:6];                    // shift
    case (op)
      4'h4, 4'h6, 4'h8, 4'h2: return (r == ir[7:6]) || (r == ir[5:4]);
      4'h0:                   return r == ir[5:4];                 // LOAD address reg
      default:                return 1'b0;
    endcase
  endfunction

  function automatic bit model_hazard();
    return m_valid && bus.valid_in && !m_halted && !bus.flush &&
           (m_ir[3:0] == 4'h0) && reads(bus.ir_in, m_ir[7:6]);
  endfunction

  task automatic model_reset();
    m_ir = 8'h0A; m_pc = 0; m_r1 = 0; m_r2 = 0;
    m_valid = 0; m_n = 0; m_z = 0; m_halted = 0;
  endtask

  task automatic model_edge(input bit hz);
    bit stop_now, flags_now, bubble;
    flags_now = m_valid && bus.flag_write && !bus.stall;
    stop_now  = m_valid && (m_ir[3:0] == 4'h1) && !bus.stall;
    bubble    = bus.flush || m_halted || (!bus.stall && hz);
    if (flags_now) begin m_n = bus.alu_n; m_z = bus.alu_z; end
    if (bubble) begin
      m_ir = 8'h0A; m_pc = 0; m_r1 = 0; m_r2 = 0; m_valid = 0;
    end else if (!bus.stall) begin
      m_ir = bus.valid_in ? bus.ir_in : 8'h0A;
      m_pc = bus.pc_in; m_r1 = bus.r1_in; m_r2 = bus.r2_in; m_valid = bus.valid_in;
    end
    if (stop_now) m_halted = 1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ir"},     bus.ir_out,    m_ir);
    check({tag, ".op"},     bus.instr_op,  m_ir[3:0]);
    check({tag, ".pc"},     bus.pc_out,    m_pc);
    check({tag, ".r1"},     bus.r1_out,    m_r1);
    check({tag, ".r2"},     bus.r2_out,    m_r2);
    check({tag, ".valid"},  bus.valid_out, m_valid);
    check({tag, ".n"},      bus.NwireOut,  m_n);
    check({tag, ".z"},      bus.ZwireOut,  m_z);
    check({tag, ".halted"}, bus.halted,    m_halted);
  endtask

  task automatic drive(input logic [7:0] ir, input logic v, input logic st, input logic fl,
                       input logic fw, input logic n, input logic z);
    bus.ir_in = ir; bus.valid_in = v; bus.stall = st; bus.flush = fl;
    bus.flag_write = fw; bus.alu_n = n; bus.alu_z = z;
    bus.pc_in = 8'($urandom); bus.r1_in = 8'($urandom); bus.r2_in = 8'($urandom);
  endtask

  // One clock: check combinational hazard, clock the model alongside the DUT, check state.
  task automatic step(input string tag);
    bit hz;
    #1;
    hz = model_hazard();
    check({tag, ".hazard"}, bus.hazard_stall, hz);
    @(posedge clock);
    model_edge(hz);
    #1;
    check_all(tag);
    $display("cycle %s ir_in=%02h v=%0b st=%0b fl=%0b -> ir_out=%02h valid=%0b N=%0b Z=%0b halt=%0b",
             tag, bus.ir_in, bus.valid_in, bus.stall, bus.flush, bus.ir_out,
             bus.valid_out, bus.NwireOut, bus.ZwireOut, bus.halted);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clock);
    #1;
    check_all({tag, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset with garbage inputs.
    drive(8'($urandom), 1, 0, 0, 1, 1, 1);
    do_reset("rst0");
    check("rst0.op_nop", bus.instr_op, 4'hA);

    drive(8'h64, 1, 0, 0, 0, 0, 0);
    step("first");
    check("first.ir64", bus.ir_out, 8'h64);

    // Load-use hazard.
    drive(8'h40, 1, 0, 0, 0, 0, 0); step("load");
    drive(8'h14, 1, 0, 0, 0, 0, 0); #1;
    check("loaduse.hz", bus.hazard_stall, 1);
    step("loaduse");
    check("loaduse.bubble", bus.ir_out, 8'h0A);
    drive(8'h40, 1, 0, 0, 0, 0, 0); step("load2");
    drive(8'h24, 1, 0, 0, 0, 0, 0); #1;
    check("nohaz.hz", bus.hazard_stall, 0);
    step("nohaz");

    // Flush beats stall; flags blocked by stall.
    drive(8'h06, 1, 1, 1, 1, 1, 0); step("flushstall");
    check("flushstall.valid", bus.valid_out, 0);

    // SUB sets flags, following BZ leaves them.
    drive(8'h06, 1, 0, 0, 0, 0, 0); step("sub");
    drive(8'h05, 1, 0, 0, 1, 0, 1); step("subflags");
    check("subflags.z", bus.ZwireOut, 1);
    check("subflags.n", bus.NwireOut, 0);
    drive(8'h24, 1, 0, 0, 0, 1, 0); step("bzhold");
    check("bzhold.z", bus.ZwireOut, 1);

    // STOP halts; later instructions never latch.
    drive(8'h01, 1, 0, 0, 0, 0, 0); step("stop");
    drive(8'h0A, 0, 0, 0, 0, 0, 0); step("stopx");
    check("stop.halted", bus.halted, 1);
    for (int i = 0; i < 3; i++) begin
      drive(8'h04, 1, 0, 0, 0, 0, 0); step("halted");
      check("halted.ir", bus.ir_out, 8'h0A);
    end
    do_reset("rst1");
    check("rst1.halted", bus.halted, 0);

    // Stall hold, then async reset mid-stall.
    drive(8'h64, 1, 0, 0, 0, 0, 0); step("prestall");
    drive(8'h40, 1, 0, 0, 0, 0, 0); step("prestall2");
    for (int i = 0; i < 3; i++) begin
      drive(8'(8'h10 + i), 1, 1, 0, 1, 1, 1); step("stall");
      check("stall.ir", bus.ir_out, 8'h40);
    end
    #2;
    do_reset("rst2");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ir;
      ir = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ir[3:0] = 4'h0;
      drive(ir, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 29) == 0) begin
        #2;
        do_reset("rrst");
      end else begin
        step("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage3_issue_latch.md
Name: stage3_issue_latch

Overview:
Pipeline register between register-read (stage 2) and execute (stage 3). Latches the instruction, PC and operands, and presents the opcode nibble to the stage-3 control decoder. Inserts NOP bubbles on flush and on load-use hazards. Owns the N/Z flag register that feeds branch resolution, and the sticky halt on STOP.

Parameters:
DATA_W, 8, width of IR, PC and register operands
NOP_IR, 8'h0A, IR pattern injected as a bubble (opcode nibble 1010 = NOP)
ORI_SRC, 2'b01, register index implicitly read by ORI (k1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ir_in  in  DATA_W  instruction from stage 2
pc_in  in  DATA_W  PC of that instruction
r1_in  in  DATA_W  value read from reg field ir_in[7:6]
r2_in  in  DATA_W  value read from reg field ir_in[5:4]
valid_in  in  1  stage-2 content is a real instruction
stall  in  1  external hold (memory wait); freezes this stage
flush  in  1  taken branch in stage 3; kill incoming instruction
alu_n  in  1  ALU result sign bit, current stage-3 instruction
alu_z  in  1  ALU result zero, current stage-3 instruction
flag_write  in  1  FlagWrite from the stage-3 decoder
instr_op  out  4  ir_out[3:0], to the decoder Instr input
ir_out  out  DATA_W  latched instruction
pc_out  out  DATA_W  latched PC
r1_out  out  DATA_W  latched operand 1
r2_out  out  DATA_W  latched operand 2
valid_out  out  1  latched content is real
NwireOut  out  1  N flag register
ZwireOut  out  1  Z flag register
hazard_stall  out  1  combinational; upstream stages must hold
halted  out  1  sticky; STOP has executed

Behaviour:
- Reset, asynchronous: ir_out=NOP_IR, pc_out/r1_out/r2_out=0, valid_out=0, NwireOut=0, ZwireOut=0, halted=0.
- Latency: one cycle, ir_in -> ir_out.
- Update priority at each rising edge, highest first:
  1. flush or halted: load bubble (ir_out=NOP_IR, valid_out=0; pc/r1/r2 = 0).
  2. stall: hold all latched values.
  3. hazard_stall: load bubble.
  4. else: load ir_in, pc_in, r1_in, r2_in, valid_in. If valid_in=0, ir_out = NOP_IR regardless of ir_in.
- Flush overrides stall in the same cycle.
- hazard_stall = valid_out & valid_in & ~halted & (ir_out[3:0]==0000, LOAD) & source(ir_in) matches dest ir_out[7:6].
- Source registers by incoming opcode:
  - ADD/SUB/NAND/STORE: [7:6] and [5:4].
  - LOAD: [5:4].
  - Shift (xx011): [7:6].
  - ORI (xx111): ORI_SRC.
  - Branches, NOP, STOP: none.
- hazard_stall is forced to 0 while flush=1, since the incoming instruction is killed.
- Flags: on an edge where valid_out & flag_write & ~stall, NwireOut<=alu_n and ZwireOut<=alu_z; otherwise hold. The flags are updated even if flush is asserted in that cycle.
- Halt: on an edge where valid_out & instr_op==0001 & ~stall, set halted=1. It stays set until reset, and the stage emits bubbles thereafter.
- Reset mid-stall or mid-hazard returns to the reset state immediately. No pending hazard survives reset.

Test Plan:
- Reset with garbage on inputs, then release → instr_op=1010, valid_out=0, N=Z=0, halted=0. Next edge with ir_in=8'h64, valid_in=1 → ir_out=8'h64 one cycle later.
- LOAD 8'h40 (dest r1) in stage 3, ir_in=8'h14 (ADD r0,r1) → hazard_stall=1; next edge ir_out=NOP_IR. With ir_in=8'h24 (ADD r0,r2) → hazard_stall=0.
- flush=1 and stall=1 together, ir_in=8'h06 → bubble loaded, valid_out=0. Flags update only if the current stage-3 instruction has flag_write=1.
- SUB in stage 3 with flag_write=1, alu_z=1, alu_n=0 → Z=1, N=0 after the edge. Following BZ with flag_write=0 → flags unchanged.
- STOP 8'h01 valid in stage 3 → halted=1 after the edge. Subsequent ir_in=8'h04 is never latched (ir_out stays 8'h0A). Reset clears halted.
- stall held 3 cycles with ir_in changing → ir_out, pc_out, r1_out, r2_out, flags and halted all hold. Assert reset during the stall → all outputs return to reset values asynchronously.
